score_topk_sorter: RTL and testbench

Streaming pre-stage of the NMS pipeline that feeds the suppression core. It accepts one candidate box per cycle, drops candidates at or below a confidence threshold, and keeps the K highest-scoring survivors in a sorted register array. At end of frame it drains the survivors to the suppression stage in descending score order.

---
 rtl/score_topk_sorter.sv | 142 ++++++++++++++
 tb/tb_score_topk_sorter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_topk_sorter.sv
// Streaming top-K score sorter: keeps the K highest-scoring candidates above a
// threshold in a descending register array, then drains them at end of frame.
module score_topk_sorter #(
  parameter int K         = 8,
  parameter int PAYLOAD_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            cfg_thresh,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_score,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_score,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic                   out_last,
  output logic                   frame_done,
  output logic [$clog2(K):0]     count
);

  localparam int IW = $clog2(K);
  localparam int CW = IW + 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [IW-1:0]      rd_idx_reg, rd_idx_next;
  logic               in_ready_reg;
  logic               frame_done_reg, frame_done_next;

  logic [15:0]          score_reg   [K];
  logic [PAYLOAD_W-1:0] payload_reg [K];
  logic [15:0]          score_next   [K];
  logic [PAYLOAD_W-1:0] payload_next [K];

  logic [K-1:0] ins;
  logic         accept;
  logic         do_insert;
  logic         out_hs;

  // Raw float16 sign-magnitude ordering; equal bit patterns are not greater.
  function automatic logic f16_gt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15])
      return b[15];
    else if (!a[15])
      return a[14:0] > b[14:0];
    else
      return a[14:0] < b[14:0];
  endfunction

  assign accept    = in_valid && in_ready && (state_reg == COLLECT);
  assign do_insert = accept && f16_gt(in_score, cfg_thresh) && ins[K-1];

  // ins is monotone (0..0 1..1) because the array is kept sorted; empty slots
  // always accept, so the first set bit is the insertion point.
  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    assign ins[gi] = (CW'(gi) >= count_reg) || f16_gt(in_score, score_reg[gi]);

    if (gi == 0) begin : g_head
      assign score_next[gi]   = ins[gi] ? in_score   : score_reg[gi];
      assign payload_next[gi] = ins[gi] ? in_payload : payload_reg[gi];
    end else begin : g_body
      assign score_next[gi]   = !ins[gi]   ? score_reg[gi]   :
                                ins[gi-1]  ? score_reg[gi-1] : in_score;
      assign payload_next[gi] = !ins[gi]   ? payload_reg[gi]   :
                                ins[gi-1]  ? payload_reg[gi-1] : in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (do_insert) begin
      for (int i = 0; i < K; i++) begin
        score_reg[i]   <= score_next[i];
        payload_reg[i] <= payload_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= COLLECT;
      count_reg      <= '0;
      rd_idx_reg     <= '0;
      in_ready_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      rd_idx_reg     <= rd_idx_next;
      in_ready_reg   <= (state_next == COLLECT);
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    rd_idx_next     = rd_idx_reg;
    frame_done_next = 1'b0;
    out_valid       = 1'b0;
    out_last        = 1'b0;
    out_hs          = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (do_insert && (count_reg != CW'(K)))
          count_next = count_reg + CW'(1);
        if (accept && in_last)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (count_reg == '0) begin
          state_next = COLLECT;
        end else begin
          out_valid = 1'b1;
          out_last  = ({1'b0, rd_idx_reg} == (count_reg - CW'(1)));
          out_hs    = out_ready;
          if (out_hs && out_last) begin
            state_next      = COLLECT;
            count_next      = '0;
            rd_idx_next     = '0;
            frame_done_next = 1'b1;
          end else if (out_hs) begin
            rd_idx_next = rd_idx_reg + IW'(1);
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // An empty frame reports completion in its single drain cycle.
  assign frame_done  = frame_done_reg || ((state_reg == DRAIN) && (count_reg == '0));
  assign in_ready    = in_ready_reg;
  assign out_score   = score_reg[rd_idx_reg];
  assign out_payload = payload_reg[rd_idx_reg];
  assign count       = count_reg;

endmodule

// File: tb/tb_score_topk_sorter.sv
// Scoreboard bench for score_topk_sorter: a stable top-K selection model feeds
// an expected-output queue that a negedge monitor checks against the drain.
module tb_score_topk_sorter;
  localparam int K  = 8;
  localparam int PW = 64;
  localparam int CW = $clog2(K) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   cfg_thresh;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_score;
  logic [PW-1:0] in_payload;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_score;
  logic [PW-1:0] out_payload;
  logic          out_last;
  logic          frame_done;
  logic [CW-1:0] count;

  score_topk_sorter #(.K(K), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_thresh(cfg_thresh),
    .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
    .in_payload(in_payload), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_score(out_score),
    .out_payload(out_payload), .out_last(out_last),
    .frame_done(frame_done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   s;
    logic [PW-1:0] p;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  logic [15:0]   fr_s[$];
  logic [PW-1:0] fr_p[$];
  int checks = 0, errors = 0, done_exp = 0, done_seen = 0, bp_mode = 1;

  // Map float16 onto an unsigned key whose integer order is the score order.
  function automatic logic [15:0] key(input logic [15:0] a);
    return a[15] ? {1'b0, ~a[14:0]} : {1'b1, a[14:0]};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stable selection: the earliest of equal scores wins, which is what the
  // insert-after-equals rule produces.
  task automatic finish_frame(output int take);
    int n;
    n = fr_s.size();
    take = (n < K) ? n : K;
    for (int t = 0; t < take; t++) begin
      int best;
      exp_t e;
      best = 0;
      for (int i = 1; i < fr_s.size(); i++)
        if (key(fr_s[i]) > key(fr_s[best])) best = i;
      e.s = fr_s[best];
      e.p = fr_p[best];
      e.l = (t == take - 1);
      sb.push_back(e);
      fr_s.delete(best);
      fr_p.delete(best);
    end
    fr_s.delete();
    fr_p.delete();
    done_exp++;
  endtask

  task automatic drive(input logic [15:0] s, input logic [PW-1:0] p,
                       input logic [15:0] th, input bit last, input bit gaps);
    int guard, take;
    guard = 0;
    while (!in_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    cfg_thresh = th; in_score = s; in_payload = p; in_last = last; in_valid = 1'b1;
    @(posedge clk);
    if (key(s) > key(th)) begin
      fr_s.push_back(s);
      fr_p.push_back(p);
    end
    take = -1;
    if (last) finish_frame(take);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (last) begin
      check("in_ready_after_last", in_ready, 0);
      if (take == 0) begin
        check("empty_frame_done", frame_done, 1);
        check("empty_no_valid", out_valid, 0);
      end else begin
        check("first_out_latency", out_valid, 1);
      end
    end else if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!in_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_complete", in_ready, 1);
    check("count_cleared", count, 0);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  function automatic logic [15:0] rand_score();
    case ($urandom_range(0, 2))
      0:       return 16'h3C00 + 16'($urandom_range(0, 3));
      1:       return 16'hBC00 + 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks drained entries, stall stability and frame_done pulses.
  initial begin
    bit            stall_prev;
    logic [15:0]   s_prev;
    logic [PW-1:0] p_prev;
    logic          l_prev;
    exp_t          e;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        if (frame_done) done_seen++;
        if (out_valid) check("in_ready_low_in_drain", in_ready, 0);
        if (stall_prev) begin
          check("stall_valid_held", out_valid, 1);
          check("stall_score_held", out_score, s_prev);
          check("stall_payload_held", out_payload, p_prev);
          check("stall_last_held", out_last, l_prev);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", out_score, 16'hxxxx);
          end else begin
            e = sb.pop_front();
            check("out_score", out_score, e.s);
            check("out_payload", out_payload, e.p);
            check("out_last", out_last, e.l);
          end
        end
        stall_prev = out_valid && !out_ready;
        s_prev = out_score; p_prev = out_payload; l_prev = out_last;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sc1[4];
    sc1 = '{16'h3800, 16'h4000, 16'h3A00, 16'h3C00};
    rst_n = 1'b0; cfg_thresh = '0; in_valid = 0; in_score = '0; in_payload = '0;
    in_last = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_count", count, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1);

    bp_mode = 1;
    for (int i = 0; i < 4; i++) drive(sc1[i], PW'(i + 1), 16'h3400, i == 3, 0);
    wait_idle();

    bp_mode = 0;
    for (int i = 0; i < 10; i++) drive(16'h3C01 + 16'(i), PW'(100 + i), 16'hBC00, i == 9, 1);
    wait_idle();

    drive(16'h3C00, 1, 16'h3C00, 0, 0);
    drive(16'h3800, 2, 16'h3C00, 0, 0);
    drive(16'hBC00, 3, 16'h3C00, 1, 0);
    wait_idle();

    drive(16'h3C00, 1, 16'hFC00, 0, 0);
    drive(16'h3C00, 2, 16'hFC00, 0, 0);
    drive(16'h0000, 3, 16'hFC00, 0, 0);
    drive(16'h8000, 4, 16'hFC00, 1, 0);
    wait_idle();

    // Reset during a stalled drain: entries vanish and that frame never completes.
    bp_mode = 2;
    for (int i = 0; i < 5; i++) drive(16'h4000 + 16'(i), PW'(200 + i), 16'h0000, i == 4, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_drain_rst_valid", out_valid, 0);
    check("mid_drain_rst_count", count, 0);
    check("mid_drain_rst_ready", in_ready, 0);
    sb.delete();
    done_exp--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bp_mode = 1;
    drive(16'h3555, 7, 16'h0000, 0, 0);
    drive(16'h3666, 8, 16'h0000, 1, 0);
    wait_idle();

    bp_mode = 0;
    for (int f = 0; f < 20; f++) begin
      int n;
      logic [15:0] th;
      n = $urandom_range(1, 12);
      th = (f % 4 == 0) ? rand_score() : 16'hBC00;
      for (int i = 0; i < n; i++) begin
        if (f % 5 == 4) th = rand_score();
        drive(rand_score(), {32'($urandom), 32'($urandom)}, th, i == n - 1, 1);
      end
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    check("frame_done_count", done_seen, done_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
